// File: rtl/spi_write_controller.sv
// SPI mode-0 write initiator: shifts {1'b1, addr, wdata} out MSB first as one 16-bit frame.
// Every non-idle phase lasts CLK_DIV clocks; a trailing GAP keeps ncs high before done.
module spi_write_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);
  localparam int DIV_W_RAW = $clog2(CLK_DIV + 1);
  localparam int DIV_W     = (DIV_W_RAW < 1) ? 1 : DIV_W_RAW;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [15:0]      r_shift;
  logic [3:0]       r_bit_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_busy;
  logic             r_done;
  logic             r_sclk;
  logic             r_copi;
  logic             r_ncs;
  logic             w_phase_end;

  assign w_phase_end = (r_div == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_copi    <= 1'b0;
      r_ncs     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_state   <= S_LEAD;
          r_shift   <= {1'b1, addr, wdata};
          r_bit_cnt <= '0;
          r_div     <= DIV_LOAD;
          r_busy    <= 1'b1;
          r_ncs     <= 1'b0;
          r_sclk    <= 1'b0;
          // The first bit on the wire is always the write flag.
          r_copi    <= 1'b1;
        end
      end else if (!w_phase_end) begin
        r_div <= r_div - 1'b1;
      end else begin
        r_div <= DIV_LOAD;
        case (r_state)
          S_LEAD: begin
            r_state <= S_HIGH;
            r_sclk  <= 1'b1;
          end
          S_HIGH: begin
            r_sclk <= 1'b0;
            if (r_bit_cnt == LAST_BIT) begin
              r_state   <= S_TRAIL;
              r_bit_cnt <= '0;
            end else begin
              // Falling edge: present the next bit so it is stable before the next rise.
              r_state   <= S_LOW;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= {r_shift[14:0], r_shift[15]};
              r_copi    <= r_shift[14];
            end
          end
          S_LOW: begin
            r_state <= S_HIGH;
            r_sclk  <= 1'b1;
          end
          S_TRAIL: begin
            r_state <= S_GAP;
            r_ncs   <= 1'b1;
            r_copi  <= 1'b0;
          end
          S_GAP: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sclk = r_sclk;
  assign copi = r_copi;
  assign ncs  = r_ncs;
endmodule
